// File: rtl/dpra_pkg.sv
// -----------------------------------------------------------------------------
// dpra_pkg
// Shared types and constants for the dual-port RAM arbiter.
//   state_e            : controller state (zero-fill sequence, normal operation)
//   DEFAULT_ADDR_WIDTH : default RAM address width
//   DEPTH              : RAM depth for the default address width
//   depth()            : RAM depth for an arbitrary address width
// -----------------------------------------------------------------------------
package dpra_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int DEFAULT_ADDR_WIDTH = 12;

    function automatic int unsigned depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    localparam int unsigned DEPTH = depth(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
//   req[1:0]  in  : request per requester
//   last      in  : requester granted most recently on this port
//   gnt[1:0]  out : one-hot grant (or zero when nobody requests)
//   next_last out : value for the caller's last register; follows the grant,
//                   holds when nothing is granted
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       next_last
);

    always_comb begin
        gnt       = 2'b00;
        next_last = last;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Contention: the requester that did not go last wins.
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (gnt[1]) begin
            next_last = 1'b1;
        end else if (gnt[0]) begin
            next_last = 1'b0;
        end
    end

endmodule

// File: rtl/dual_port_ram_arbiter.sv
// -----------------------------------------------------------------------------
// dual_port_ram_arbiter
// Shares one RAM (one write port, one read port, 1-cycle registered read)
// between two requesters. Write and read ports are arbitrated independently
// with 2-way round-robin. After reset the RAM is optionally zero-filled
// before any access is granted.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   init_busy            : high while the zero-fill sequence runs
//   req/we/addr/wdata N  : requester N access (held until gntN)
//   gntN                 : combinational grant, access happens this cycle
//   rvalidN              : rdata carries read data for requester N
//   rdata                : shared read data (straight from the RAM)
//   ram_we/ram_waddr/ram_wdata/ram_raddr/ram_rdata : RAM port connections
// -----------------------------------------------------------------------------
module dual_port_ram_arbiter
    import dpra_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  init_busy,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,

    output logic [DATA_WIDTH-1:0] rdata,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int unsigned RAM_DEPTH = depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_e                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  rvalid0_q,  rvalid0_d;
    logic                  rvalid1_q,  rvalid1_d;
    logic                  wr_last_q,  wr_last_d;
    logic                  rd_last_q,  rd_last_d;

    logic       run;
    logic [1:0] wr_req, rd_req;
    logic [1:0] wr_gnt, rd_gnt;
    logic       wr_next_last, rd_next_last;

    // Requests are masked during the clear sequence; they remain asserted
    // at the inputs and are served once RUN is reached.
    assign run    = (state_q == ST_RUN);
    assign wr_req = {2{run}} & {req1 &  we1, req0 &  we0};
    assign rd_req = {2{run}} & {req1 & ~we1, req0 & ~we0};

    rr_arb2 u_wr_arb (
        .req       (wr_req),
        .last      (wr_last_q),
        .gnt       (wr_gnt),
        .next_last (wr_next_last)
    );

    rr_arb2 u_rd_arb (
        .req       (rd_req),
        .last      (rd_last_q),
        .gnt       (rd_gnt),
        .next_last (rd_next_last)
    );

    assign gnt0      = wr_gnt[0] | rd_gnt[0];
    assign gnt1      = wr_gnt[1] | rd_gnt[1];
    assign init_busy = ~run;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata     = ram_rdata;

    // RAM port muxes
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_raddr = '0;
        if (!run) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
        end else begin
            if (wr_gnt[0]) begin
                ram_we    = 1'b1;
                ram_waddr = addr0;
                ram_wdata = wdata0;
            end else if (wr_gnt[1]) begin
                ram_we    = 1'b1;
                ram_waddr = addr1;
                ram_wdata = wdata1;
            end
            if (rd_gnt[0]) begin
                ram_raddr = addr0;
            end else if (rd_gnt[1]) begin
                ram_raddr = addr1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        rvalid0_d  = rd_gnt[0];
        rvalid1_d  = rd_gnt[1];
        wr_last_d  = wr_next_last;
        rd_last_d  = rd_next_last;
        if (!run) begin
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            if (clr_addr_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_addr_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            // "Requester 1 went last" so requester 0 wins the first tie.
            wr_last_q  <= 1'b1;
            rd_last_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            wr_last_q  <= wr_last_d;
            rd_last_q  <= rd_last_d;
        end
    end

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_arbiter
// Directed bench for dual_port_ram_arbiter with a behavioural 1-cycle-read,
// read-before-write RAM (AW=4, DW=8). Expected read data is queued when a
// read grant is expected and compared when rvalid is due.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_busy;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          ram_we;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    logic          tb_fill;
    logic [DW-1:0] mem    [NW];
    logic [DW-1:0] shadow [NW];

    typedef struct packed {
        logic          who;
        logic [DW-1:0] data;
    } rd_exp_t;
    rd_exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dual_port_ram_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .init_busy (init_busy),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    // Behavioural RAM; tb_fill poisons every word so the clear is observable.
    always @(posedge clk) begin
        if (tb_fill) begin
            for (int i = 0; i < NW; i++) mem[i] <= 8'hEE;
        end else if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rvalid(input string tag);
        rd_exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "/rvalid0"}, {31'b0, rvalid0}, {31'b0, ~e.who});
            chk({tag, "/rvalid1"}, {31'b0, rvalid1}, {31'b0,  e.who});
            chk({tag, "/rdata"},   {24'b0, rdata},   {24'b0,  e.data});
        end else begin
            chk({tag, "/rvalid0"}, {31'b0, rvalid0}, 32'd0);
            chk({tag, "/rvalid1"}, {31'b0, rvalid1}, 32'd0);
        end
    endtask

    // One RUN cycle: drive, check outputs against expected grants, update model.
    task automatic cycle(input string tag,
                         input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic eg0, input logic eg1);
        logic          exp_we;
        logic [AW-1:0] exp_wa, exp_ra;
        logic [DW-1:0] exp_wd;
        rd_exp_t       e;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        @(negedge clk);
        check_rvalid(tag);
        chk({tag, "/gnt0"}, {31'b0, gnt0}, {31'b0, eg0});
        chk({tag, "/gnt1"}, {31'b0, gnt1}, {31'b0, eg1});
        chk({tag, "/init_busy"}, {31'b0, init_busy}, 32'd0);
        exp_we = 1'b0; exp_wa = '0; exp_wd = '0; exp_ra = '0;
        if (eg0 && w0) begin
            exp_we = 1'b1; exp_wa = a0; exp_wd = d0;
        end else if (eg1 && w1) begin
            exp_we = 1'b1; exp_wa = a1; exp_wd = d1;
        end
        if (eg0 && !w0) begin
            exp_ra = a0; e.who = 1'b0; e.data = shadow[a0]; sb.push_back(e);
        end else if (eg1 && !w1) begin
            exp_ra = a1; e.who = 1'b1; e.data = shadow[a1]; sb.push_back(e);
        end
        chk({tag, "/ram_we"},    {31'b0, ram_we},    {31'b0, exp_we});
        chk({tag, "/ram_waddr"}, {28'b0, ram_waddr}, {28'b0, exp_wa});
        chk({tag, "/ram_wdata"}, {24'b0, ram_wdata}, {24'b0, exp_wd});
        chk({tag, "/ram_raddr"}, {28'b0, ram_raddr}, {28'b0, exp_ra});
        if (exp_we) shadow[exp_wa] = exp_wd;
        @(posedge clk); #1;
    endtask

    // Full clear sequence; request inputs keep whatever the caller drove.
    task automatic clear_check(input string tag);
        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            check_rvalid(tag);
            chk({tag, "/init_busy"}, {31'b0, init_busy}, 32'd1);
            chk({tag, "/ram_we"},    {31'b0, ram_we},    32'd1);
            chk({tag, "/ram_waddr"}, {28'b0, ram_waddr}, i);
            chk({tag, "/ram_wdata"}, {24'b0, ram_wdata}, 32'd0);
            chk({tag, "/gnt0"},      {31'b0, gnt0},      32'd0);
            chk({tag, "/gnt1"},      {31'b0, gnt1},      32'd0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < NW; i++) shadow[i] = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; tb_fill = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        for (int i = 0; i < NW; i++) shadow[i] = 8'hEE;
        @(posedge clk); #1;
        tb_fill = 1'b0;

        // Reset state
        @(negedge clk);
        check_rvalid("reset");
        chk("reset/init_busy", {31'b0, init_busy}, 32'd1);
        chk("reset/ram_waddr", {28'b0, ram_waddr}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_check("clr1");

        // Reads after clear return zero; read ties alternate starting with 0
        cycle("rd0",     1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0);
        cycle("rd7",     1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0);
        cycle("rd15",    1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd15, 8'h00, 1'b0, 1'b1);
        cycle("rdtie_a", 1'b1, 1'b0, 4'd4, 8'h00, 1'b1, 1'b0, 4'd9,  8'h00, 1'b1, 1'b0);
        cycle("rdtie_b", 1'b1, 1'b0, 4'd4, 8'h00, 1'b1, 1'b0, 4'd9,  8'h00, 1'b0, 1'b1);
        cycle("rdtie_c", 1'b1, 1'b0, 4'd4, 8'h00, 1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0);

        // Continuous writes from both: grants 0,1,0,1
        cycle("wr_a", 1'b1, 1'b1, 4'd1, 8'h11, 1'b1, 1'b1, 4'd2, 8'h22, 1'b1, 1'b0);
        cycle("wr_b", 1'b1, 1'b1, 4'd1, 8'h11, 1'b1, 1'b1, 4'd2, 8'h22, 1'b0, 1'b1);
        cycle("wr_c", 1'b1, 1'b1, 4'd1, 8'h11, 1'b1, 1'b1, 4'd2, 8'h22, 1'b1, 1'b0);
        cycle("wr_d", 1'b1, 1'b1, 4'd1, 8'h11, 1'b1, 1'b1, 4'd2, 8'h22, 1'b0, 1'b1);
        cycle("rd_a1", 1'b1, 1'b0, 4'd1, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
        cycle("rd_a2", 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b1);

        // Write by 0 then read by 1 of the same address
        cycle("b_wr",   1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0);
        cycle("b_rd",   1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b1);

        // Same-cycle write and read of one address: old data, then new
        cycle("e_same",   1'b1, 1'b1, 4'd5, 8'h5A, 1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b1);
        cycle("e_reread", 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b1);
        cycle("idle1",    1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);

        // Reset in a cycle with a read granted: its rvalid must never appear
        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0;   wdata0 = '0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd6; wdata1 = '0;
        @(negedge clk);
        check_rvalid("rst_run");
        chk("rst_run/gnt1",      {31'b0, gnt1},      32'd1);
        chk("rst_run/ram_raddr", {28'b0, ram_raddr}, 32'd6);
        @(posedge clk); #1;
        reset = 1'b0;

        // Both requesters hold writes through the clear
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd1; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd2; wdata1 = 8'h22;
        clear_check("clr2");
        cycle("d_first",  1'b1, 1'b1, 4'd1, 8'h11, 1'b1, 1'b1, 4'd2, 8'h22, 1'b1, 1'b0);
        cycle("d_second", 1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd2, 8'h22, 1'b0, 1'b1);
        cycle("d_rd1",    1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0);
        cycle("d_rd3",    1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b1);
        cycle("idle2",    1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
